// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and a DMA requester.
// Optional per-side activity counters are compiled in when ARB_STATS_EN is defined.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] stat_dma_beats,
  output logic [15:0] stat_cpu_stalls
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);

  state_t           state_reg;
  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] burst_cnt_reg;
  logic [CNT_W-1:0] burst_cnt_next;
  logic             dma_rvalid_reg;
  logic             cpu_req;
  logic             starved;
  logic             dma_sel;

  always_comb begin
    cpu_req        = cpu_mem_read | cpu_mem_write;
    starved        = (starve_cnt_reg == STARVE_MAX);
    burst_cnt_next = burst_cnt_reg + 1'b1;
    // Cooldown always beats starvation so the CPU is guaranteed its cycle.
    dma_sel = dma_req & (~cpu_req | (state_reg == BURST) | starved)
                      & ~((state_reg == COOLDOWN) & cpu_req);
  end

  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (dma_sel) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_read  = ~dma_we;
      mem_write = dma_we;
    end else if (cpu_req) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_read  = cpu_mem_read;
      mem_write = cpu_mem_write;
    end
  end

  assign dma_gnt    = dma_sel;
  assign cpu_stall  = cpu_req & dma_sel;
  assign dma_rvalid = dma_rvalid_reg;
  assign dma_rdata  = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      burst_cnt_reg  <= '0;
      dma_rvalid_reg <= 1'b0;
    end else begin
      dma_rvalid_reg <= dma_sel & ~dma_we;

      if (dma_sel || !dma_req) begin
        starve_cnt_reg <= '0;
      end else if (!starved) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (dma_sel && dma_lock) begin
            state_reg     <= BURST;
            burst_cnt_reg <= CNT_W'(1);
          end
        end
        BURST: begin
          // In BURST every requested beat is granted, so dma_req alone marks a beat.
          if (!dma_req) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
          end else if (burst_cnt_next >= BURST_MAX) begin
            state_reg     <= COOLDOWN;
            burst_cnt_reg <= '0;
          end else if (!dma_lock) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
          end else begin
            burst_cnt_reg <= burst_cnt_next;
          end
        end
        COOLDOWN: begin
          state_reg     <= IDLE;
          burst_cnt_reg <= '0;
        end
        default: begin
          state_reg     <= IDLE;
          burst_cnt_reg <= '0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stat_beats_reg;
  logic [15:0] stat_stalls_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_beats_reg  <= 16'd0;
      stat_stalls_reg <= 16'd0;
    end else begin
      if (dma_sel && (stat_beats_reg != 16'hFFFF)) begin
        stat_beats_reg <= stat_beats_reg + 16'd1;
      end
      if (cpu_stall && (stat_stalls_reg != 16'hFFFF)) begin
        stat_stalls_reg <= stat_stalls_reg + 16'd1;
      end
    end
  end

  assign stat_dma_beats  = stat_beats_reg;
  assign stat_cpu_stalls = stat_stalls_reg;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a vector table of single-cycle cases followed
// by hand-written starvation, burst, cooldown and reset sequences.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_mem_read;
  logic        cpu_mem_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic        dma_lock;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_dma_beats;
  logic [15:0] stat_cpu_stalls;
`endif

  dmem_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_mem_write (cpu_mem_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_stall     (cpu_stall),
    .dma_req       (dma_req),
    .dma_we        (dma_we),
    .dma_lock      (dma_lock),
    .dma_addr      (dma_addr),
    .dma_wdata     (dma_wdata),
    .dma_gnt       (dma_gnt),
    .dma_rvalid    (dma_rvalid),
    .dma_rdata     (dma_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_rdata     (mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .stat_dma_beats  (stat_dma_beats),
    .stat_cpu_stalls (stat_cpu_stalls)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic        dreq;
    logic        dwe;
    logic        dlock;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrdata;
    logic        e_stall;
    logic        e_gnt;
    logic        e_rvalid;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_mrd;
    logic        e_mwr;
  } vec_t;

  vec_t vecs [12];
  int   n_vec;
  int   n_bad;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_mem_read  = 1'b0;
    cpu_mem_write = 1'b0;
    cpu_addr      = 32'd0;
    cpu_wdata     = 32'd0;
    dma_req       = 1'b0;
    dma_we        = 1'b0;
    dma_lock      = 1'b0;
    dma_addr      = 32'd0;
    dma_wdata     = 32'd0;
    mem_rdata     = 32'd0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //          rd    wr    caddr         cwdata        dreq  dwe   dlock daddr         dwdata        mrdata         stall gnt   rvld  maddr         mwdata        mrd   mwr
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h40,       32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h40,       32'hDEADBEEF, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h44,       32'h11111111, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h44,       32'h11111111, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h80,       32'h22222222, 32'h0,         1'b0, 1'b1, 1'b0, 32'h80,       32'h22222222, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hCAFEF00D,  1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 32'h84,       32'h33333333, 32'h0,         1'b0, 1'b1, 1'b0, 32'h84,       32'h33333333, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h5555AAAA,  1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h48,       32'h44444444, 1'b1, 1'b0, 1'b0, 32'h88,       32'h66666666, 32'h0,         1'b0, 1'b0, 1'b0, 32'h48,       32'h44444444, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h4C,       32'h77777777, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h4C,       32'h77777777, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h90,       32'h88888888, 32'h0,         1'b0, 1'b1, 1'b0, 32'h90,       32'h88888888, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h50,       32'h99999999, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h12345678,  1'b0, 1'b0, 1'b1, 32'h50,       32'h99999999, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};

    // Reset with both sides requesting: state IDLE so the CPU wins.
    idle_inputs();
    reset         = 1'b0;
    cpu_mem_read  = 1'b1;
    cpu_addr      = 32'h3C;
    dma_req       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_rvalid", dma_rvalid, 1'b0);
    chk1("rst_gnt", dma_gnt, 1'b0);
    chk1("rst_stall", cpu_stall, 1'b0);
    chk32("rst_maddr", mem_addr, 32'h3C);
    idle_inputs();
    reset = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      cpu_mem_read  = vecs[i].rd;
      cpu_mem_write = vecs[i].wr;
      cpu_addr      = vecs[i].caddr;
      cpu_wdata     = vecs[i].cwdata;
      dma_req       = vecs[i].dreq;
      dma_we        = vecs[i].dwe;
      dma_lock      = vecs[i].dlock;
      dma_addr      = vecs[i].daddr;
      dma_wdata     = vecs[i].dwdata;
      mem_rdata     = vecs[i].mrdata;
      #4;
      chk1($sformatf("v%0d_stall", i), cpu_stall, vecs[i].e_stall);
      chk1($sformatf("v%0d_gnt", i), dma_gnt, vecs[i].e_gnt);
      chk1($sformatf("v%0d_rvalid", i), dma_rvalid, vecs[i].e_rvalid);
      chk32($sformatf("v%0d_maddr", i), mem_addr, vecs[i].e_maddr);
      chk32($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].e_mwdata);
      chk1($sformatf("v%0d_mrd", i), mem_read, vecs[i].e_mrd);
      chk1($sformatf("v%0d_mwr", i), mem_write, vecs[i].e_mwr);
      chk32($sformatf("v%0d_rdata", i), dma_rdata, vecs[i].mrdata);
      $display("vec %0d applied: gnt=%b stall=%b rvalid=%b addr=%h", i, dma_gnt, cpu_stall, dma_rvalid, mem_addr);
      step();
    end

    // Starvation: eight refusals, one forced beat, then the counter starts over.
    cpu_mem_read = 1'b1;
    cpu_addr     = 32'h60;
    dma_req      = 1'b1;
    dma_addr     = 32'hA0;
    for (int c = 1; c <= 8; c++) begin
      #4;
      chk1($sformatf("starve_c%0d_gnt", c), dma_gnt, 1'b0);
      chk1($sformatf("starve_c%0d_stall", c), cpu_stall, 1'b0);
      step();
    end
    #4;
    chk1("starve_c9_gnt", dma_gnt, 1'b1);
    chk1("starve_c9_stall", cpu_stall, 1'b1);
    chk32("starve_c9_maddr", mem_addr, 32'hA0);
    chk1("starve_c9_mrd", mem_read, 1'b1);
    step();
    #4;
    chk1("starve_c10_gnt", dma_gnt, 1'b0);
    chk1("starve_c10_stall", cpu_stall, 1'b0);
    chk1("starve_c10_rvalid", dma_rvalid, 1'b1);
    chk32("starve_c10_maddr", mem_addr, 32'h60);
    $display("starvation sequence done");
    idle_inputs();
    step();
`ifdef ARB_STATS_EN
    chk32("stat_beats_starve", {16'd0, stat_dma_beats}, 32'd4);
    chk32("stat_stalls_starve", {16'd0, stat_cpu_stalls}, 32'd1);
`endif

    // Locked write burst with the CPU busy: forced first beat, 3 more, then cooldown.
    cpu_mem_read = 1'b1;
    cpu_addr     = 32'h64;
    dma_req      = 1'b1;
    dma_we       = 1'b1;
    dma_lock     = 1'b1;
    dma_addr     = 32'hB0;
    dma_wdata    = 32'hABCD0123;
    for (int c = 1; c <= 8; c++) begin
      #4;
      chk1($sformatf("burst_wait%0d_gnt", c), dma_gnt, 1'b0);
      step();
    end
    for (int b = 1; b <= 4; b++) begin
      #4;
      chk1($sformatf("burst_beat%0d_gnt", b), dma_gnt, 1'b1);
      chk1($sformatf("burst_beat%0d_stall", b), cpu_stall, 1'b1);
      chk1($sformatf("burst_beat%0d_mwr", b), mem_write, 1'b1);
      chk32($sformatf("burst_beat%0d_mwdata", b), mem_wdata, 32'hABCD0123);
      step();
    end
    #4;
    chk1("cooldown_gnt", dma_gnt, 1'b0);
    chk1("cooldown_stall", cpu_stall, 1'b0);
    chk1("cooldown_mrd", mem_read, 1'b1);
    chk32("cooldown_maddr", mem_addr, 32'h64);
    chk1("cooldown_rvalid", dma_rvalid, 1'b0);
    step();
    #4;
    chk1("post_cooldown_gnt", dma_gnt, 1'b0);
    $display("locked burst sequence done");
    idle_inputs();
    step();
`ifdef ARB_STATS_EN
    chk32("stat_beats_burst", {16'd0, stat_dma_beats}, 32'd8);
    chk32("stat_stalls_burst", {16'd0, stat_cpu_stalls}, 32'd5);
`endif

    // Burst on an idle port: the cooldown beat is granted but must not relock.
    dma_req  = 1'b1;
    dma_lock = 1'b1;
    dma_addr = 32'hC0;
    for (int b = 1; b <= 5; b++) begin
      #4;
      chk1($sformatf("idleburst_b%0d_gnt", b), dma_gnt, 1'b1);
      chk1($sformatf("idleburst_b%0d_stall", b), cpu_stall, 1'b0);
      step();
    end
    cpu_mem_write = 1'b1;
    cpu_addr      = 32'h68;
    #4;
    chk1("idleburst_after_gnt", dma_gnt, 1'b0);
    chk1("idleburst_after_stall", cpu_stall, 1'b0);
    chk1("idleburst_after_mwr", mem_write, 1'b1);
    chk1("idleburst_after_rvalid", dma_rvalid, 1'b1);
    $display("cooldown relock sequence done");
    idle_inputs();
    step();

    // Reset after beat 2 of a locked read burst.
    cpu_mem_read = 1'b1;
    cpu_addr     = 32'h6C;
    dma_req      = 1'b1;
    dma_lock     = 1'b1;
    dma_addr     = 32'hD0;
    repeat (8) step();
    #4;
    chk1("rstburst_b1_gnt", dma_gnt, 1'b1);
    step();
    #4;
    chk1("rstburst_b2_gnt", dma_gnt, 1'b1);
    step();
    chk1("rstburst_pre_rvalid", dma_rvalid, 1'b1);
    chk1("rstburst_pre_gnt", dma_gnt, 1'b1);
    reset = 1'b0;
    #1;
    chk1("rstburst_rvalid", dma_rvalid, 1'b0);
    chk1("rstburst_gnt", dma_gnt, 1'b0);
    chk1("rstburst_stall", cpu_stall, 1'b0);
`ifdef ARB_STATS_EN
    chk32("stat_beats_rst", {16'd0, stat_dma_beats}, 32'd0);
`endif
    step();
    reset = 1'b1;
    #3;
    chk1("rstburst_rel_gnt", dma_gnt, 1'b0);
    chk1("rstburst_rel_stall", cpu_stall, 1'b0);
    chk32("rstburst_rel_maddr", mem_addr, 32'h6C);
    $display("reset mid-burst sequence done");
    idle_inputs();
    step();

`ifdef ARB_STATS_EN
    // Continuous idle-port reads drive the beat counter into saturation.
    dma_req = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk32("stat_beats_sat", {16'd0, stat_dma_beats}, 32'h0000FFFF);
    chk32("stat_stalls_sat", {16'd0, stat_cpu_stalls}, 32'd0);
    $display("stats saturation sequence done");
    idle_inputs();
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single data-memory port between the CPU MEM stage and a DMA/peripheral requester. Sits between the EX/MEM boundary (CPU address, write data, MemRead, MemWrite) and DataMemory. The CPU normally has priority. A starvation counter and a bounded lock-burst FSM guarantee forward progress for both sides. When the DMA wins while the CPU wants the port, the block raises cpu_stall, which the hazard logic ORs into the pipeline stall.

Parameters:
STARVE_LIMIT, 8, cycles a pending DMA request may be refused before it is forced through.
MAX_BURST, 4, maximum consecutive locked DMA beats before the CPU is given a cycle.
CNT_W, 4, width of the starvation and burst counters; must hold max(STARVE_LIMIT, MAX_BURST).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous reset, active-low.
cpu_mem_read  in  1  CPU MEM-stage load.
cpu_mem_write  in  1  CPU MEM-stage store.
cpu_addr  in  32  CPU byte address.
cpu_wdata  in  32  CPU store data.
cpu_stall  out  1  CPU request refused this cycle; hold the pipeline.
dma_req  in  1  DMA access request, held until granted.
dma_we  in  1  1 = write, 0 = read.
dma_lock  in  1  request that the next beat continue a locked burst.
dma_addr  in  32  DMA byte address.
dma_wdata  in  32  DMA write data.
dma_gnt  out  1  DMA beat accepted this cycle.
dma_rvalid  out  1  read data for the previous granted DMA read is valid.
dma_rdata  out  32  equals mem_rdata; meaningful only when dma_rvalid = 1.
mem_addr  out  32  to DataMemory Address.
mem_wdata  out  32  to DataMemory Write_data.
mem_read  out  1  to DataMemory MemRead.
mem_write  out  1  to DataMemory MemWrite.
mem_rdata  in  32  from DataMemory; one-cycle read latency.

Behaviour:
- cpu_req = cpu_mem_read | cpu_mem_write. Selection is combinational from registered state and current inputs.
- dma_sel = dma_req & (~cpu_req | state==BURST | starve_cnt==STARVE_LIMIT) & ~(state==COOLDOWN & cpu_req).
- dma_gnt = dma_sel. cpu_stall = cpu_req & dma_sel.
- Memory mux:
  - dma_sel = 1: mem_* driven from dma_*; mem_read = ~dma_we, mem_write = dma_we.
  - dma_sel = 0: mem_* driven from cpu_*.
  - No request from either side: all mem_* outputs are 0.
- dma_rvalid is registered: dma_rvalid <= dma_sel & ~dma_we. Read latency is 1 cycle after the grant.
- starve_cnt:
  - Cleared to 0 on dma_sel or when dma_req = 0.
  - Otherwise increments by 1, saturating at STARVE_LIMIT.
- FSM states, reset value IDLE:
  - IDLE: if dma_sel & dma_lock, go to BURST with burst_cnt = 1. Otherwise stay.
  - BURST: on each granted beat burst_cnt++.
    - If dma_req = 0, or a granted beat has dma_lock = 0: go to IDLE. That last beat is still granted.
    - If burst_cnt reaches MAX_BURST on a granted beat: go to COOLDOWN regardless of dma_lock.
  - COOLDOWN: lasts exactly one cycle, then IDLE. DMA is blocked only if cpu_req = 1. With cpu_req = 0 the DMA may be granted, but its lock is ignored, so no new burst starts from COOLDOWN.
- Simultaneous events:
  - A forced starvation grant and a new lock in the same cycle start BURST.
  - COOLDOWN overrides starvation.
- Reset values: state = IDLE, starve_cnt = 0, burst_cnt = 0, dma_rvalid = 0.
- Reset asserted mid-burst returns to IDLE immediately and clears dma_rvalid. Combinational outputs then follow their inputs with state = IDLE.
- cpu_mem_read and cpu_mem_write both high is illegal. Both are passed through unchanged.

Optional Feature:
Macro ARB_STATS_EN.
- When defined: adds output ports stat_dma_beats (16) and stat_cpu_stalls (16).
  - stat_dma_beats counts dma_sel cycles.
  - stat_cpu_stalls counts cpu_stall cycles.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: these ports and their counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- CPU-only: cpu_mem_write = 1, cpu_addr = 0x40, cpu_wdata = 0xDEADBEEF, dma_req = 0 -> mem_write = 1, mem_addr = 0x40, cpu_stall = 0, dma_gnt = 0.
- Idle-port DMA read: cpu_req = 0, dma_req = 1, dma_we = 0, dma_addr = 0x80 -> dma_gnt = 1, mem_read = 1 same cycle; dma_rvalid = 1 next cycle with dma_rdata = mem_rdata.
- Starvation: cpu_mem_read held 1, dma_req held 1, STARVE_LIMIT = 8 -> dma_gnt = 0 for 8 cycles; on cycle 9 dma_gnt = 1 and cpu_stall = 1 for exactly one cycle; counter back to 0.
- Locked burst: cpu_req = 1, starvation forces the first beat, dma_lock = 1 held, MAX_BURST = 4 -> 4 consecutive grants with cpu_stall = 1, then one COOLDOWN cycle with dma_gnt = 0 and cpu_stall = 0.
- Reset mid-burst: pull reset low after beat 2 of a burst -> dma_rvalid = 0 and state IDLE. After release with cpu_req = 1 and dma_req = 1, the CPU wins (cpu_stall = 0).
- ARB_STATS_EN: run the starvation scenario -> stat_dma_beats = 1, stat_cpu_stalls = 1. Preload near max and check counters stop at 0xFFFF.
